// File: rtl/wb_host_master.sv
// wb_host_master: Wishbone classic single-transfer initiator.
// A valid/ready command becomes one cyc/stb bus transaction, and the
// result comes back on a valid/ready response channel. Only one
// transaction is in flight at a time.
//
// Optional feature macro: WB_HOST_TIMEOUT_EN
//   defined   - a saturating 16-bit counter ends a BUS phase that receives
//               no ack within TIMEOUT_CYCLES cycles. The response then has
//               rsp_err=1 and rsp_dat=0.
//   undefined - BUS waits for ack indefinitely, rsp_err is tied low and
//               TIMEOUT_CYCLES has no effect.
module wb_host_master #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // command channel
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  // response channel
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            busy,
  // wishbone initiator port
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Handshake and status flags come straight from the state register.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef WB_HOST_TIMEOUT_EN
  // Counter value on the last ack-less BUS edge allowed before giving up.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;

  // The counter stops at its maximum so that it never wraps back to a
  // value that could trigger the timeout comparison a second time.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  wire timeout_hit = (to_cnt == TO_LAST);

  // Count the BUS cycles that pass without an ack. The counter clears on
  // each command acceptance.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      if (cmd_valid) to_cnt <= '0;
    end else if (state == BUS && !wbm_ack_i) begin
      to_cnt <= sat_inc(to_cnt);
    end
  end
`else
  // No timeout path exists in this build, so the error flag stays low.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign rsp_err = 1'b0;
`endif

  // Main control FSM. It drives every registered bus and response output.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
`ifdef WB_HOST_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is high in IDLE, so cmd_valid alone completes the handshake.
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          // An ack takes priority over a timeout that falls in the same cycle.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_valid <= 1'b1;
`ifdef WB_HOST_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef WB_HOST_TIMEOUT_EN
          else if (timeout_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_dat   <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end
`endif
        end
        RESP: begin
          // The response stays held until it is consumed. A stray ack here has no effect.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
